// File: rtl/rdback_serializer.sv
// rdback_serializer: drains the softMC read-back FIFO and streams each line as OUT_WIDTH words.
// Optional macro RDBACK_SER_HDR_EN prefixes every line with a 16'hCAFE/sequence header word.
module rdback_serializer #(
  parameter int TCQ       = 100,
  parameter int DQ_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdback_fifo_empty,
  output logic                    rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]   rdback_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_WIDTH-1:0]    m_data,
  output logic                    m_last,
  output logic [31:0]             lines_sent,
  output logic                    busy
);

  localparam int LW = 4 * DQ_WIDTH;
  localparam int N  = LW / OUT_WIDTH;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  if ((LW % OUT_WIDTH) != 0 || N < 2 || TCQ < 0) begin : g_bad_cfg
    $error("rdback_serializer: illegal parameter set");
  end

`ifdef RDBACK_SER_HDR_EN
  if (OUT_WIDTH < 32) begin : g_bad_hdr
    $error("rdback_serializer: header needs OUT_WIDTH >= 32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HDR,
    S_SEND
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [LW-1:0]        r_sreg;
  logic [CW-1:0]        r_cnt;
  logic [31:0]          r_lines;
  logic                 w_at_last;
  logic                 w_line_done;
  logic                 w_rden;

`ifdef RDBACK_SER_HDR_EN
  logic [15:0]          r_seq;
  logic [OUT_WIDTH-1:0] w_hdr;
  logic                 w_hdr_xfer;

  always_comb begin
    w_hdr       = '0;
    w_hdr[31:0] = {16'hCAFE, r_seq};
  end
`endif

  assign w_at_last = (r_cnt == LAST_IDX);

  always_comb begin
    w_next      = r_state;
    w_rden      = 1'b0;
    w_line_done = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
`ifdef RDBACK_SER_HDR_EN
    w_hdr_xfer  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!rdback_fifo_empty) begin
          w_rden = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef RDBACK_SER_HDR_EN
        w_next = S_HDR;
`else
        w_next = S_SEND;
`endif
      end
`ifdef RDBACK_SER_HDR_EN
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = w_hdr;
        if (m_ready) begin
          w_hdr_xfer = 1'b1;
          w_next     = S_SEND;
        end
      end
`endif
      S_SEND: begin
        m_valid = 1'b1;
        m_data  = r_sreg[OUT_WIDTH-1:0];
        m_last  = w_at_last;
        if (m_ready && w_at_last) begin
          w_line_done = 1'b1;
          // Back-to-back: pop the next line while the last word leaves.
          if (!rdback_fifo_empty) begin
            w_rden = 1'b1;
            w_next = S_LOAD;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_lines <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        r_sreg <= rdback_data;
        r_cnt  <= '0;
      end else if (r_state == S_SEND && m_ready && !w_at_last) begin
        r_sreg <= r_sreg >> OUT_WIDTH;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_line_done) begin
        r_lines <= r_lines + 32'd1;
      end
    end
  end

`ifdef RDBACK_SER_HDR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
    end else if (w_hdr_xfer) begin
      r_seq <= r_seq + 16'd1;
    end
  end
`endif

  // The pop must not leak out during the reset cycle.
  assign rdback_fifo_rden = w_rden & ~rst;
  assign lines_sent       = r_lines;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_rdback_serializer.sv
// tb_rdback_serializer: directed and random stimulus for rdback_serializer
// against a queue-based line/word model of the read-back stream.
module tb_rdback_serializer;

  localparam int DQ  = 64;
  localparam int OW  = 32;
  localparam int LW  = 4 * DQ;
  localparam int N   = LW / OW;
`ifdef RDBACK_SER_HDR_EN
  localparam int WPL = N + 1;
`else
  localparam int WPL = N;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic          rden;
  logic [LW-1:0] rdata;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_last;
  logic [31:0]   lines_sent;
  logic          busy;

  always #5 clk = ~clk;

  rdback_serializer #(
    .TCQ(100),
    .DQ_WIDTH(DQ),
    .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdback_fifo_empty(empty),
    .rdback_fifo_rden(rden),
    .rdback_data(rdata),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .lines_sent(lines_sent),
    .busy(busy)
  );

  logic [LW-1:0] fifo[$];
  logic [LW-1:0] infl[$];
  int            idx;
  logic [31:0]   exp_lines;
  logic [15:0]   seq;
  int            vectors;
  int            miscompares;
  int            want_valid;
  longint        want_lines;
  logic          hold_empty;
  logic          p_hold;
  logic [OW-1:0] p_data;
  logic          p_last;
  int            rden_cnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] exp_word();
    logic [LW-1:0] ln;
    int            k;
    ln = infl[0];
    k  = idx;
`ifdef RDBACK_SER_HDR_EN
    if (idx == 0) return {16'hCAFE, seq};
    k = idx - 1;
`endif
    return ln[k*OW +: OW];
  endfunction

  task automatic step();
    logic          xfer;
    logic          rd_s;
    logic          rst_s;
    logic          pop;
    logic          ex_rden;
    logic [LW-1:0] ln;
    @(negedge clk);
    rst_s = rst;
    xfer  = m_valid && m_ready && !rst;
    rd_s  = rden;
    ex_rden = !rst && !empty &&
              (infl.size() == 0 || (xfer && idx == WPL - 1));
    chk("rden", 64'(rden), 64'(ex_rden));
    chk("busy", 64'(busy), 64'(infl.size() != 0));
    chk("lines_sent", 64'(lines_sent), 64'(exp_lines));
    if (infl.size() == 0) chk("idle_valid", 64'(m_valid), 64'd0);
    if (p_hold) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data", 64'(m_data), 64'(p_data));
      chk("hold_last", 64'(m_last), 64'(p_last));
    end
    if (xfer) begin
      if (infl.size() == 0) begin
        chk("spurious_xfer", 64'd1, 64'd0);
      end else begin
        chk("m_data", 64'(m_data), 64'(exp_word()));
        chk("m_last", 64'(m_last), 64'(idx == WPL - 1));
      end
    end
    if (want_valid >= 0) begin
      chk("m_valid", 64'(m_valid), 64'(want_valid));
      want_valid = -1;
    end
    if (want_lines >= 0) begin
      chk("lines_at", 64'(lines_sent), 64'(want_lines));
      want_lines = -1;
    end
    p_hold = !rst && m_valid && !m_ready;
    p_data = m_data;
    p_last = m_last;
    @(posedge clk);
    pop = 1'b0;
    if (rst_s) begin
      infl.delete();
      idx       = 0;
      seq       = '0;
      exp_lines = '0;
    end else begin
      if (xfer && infl.size() != 0) begin
`ifdef RDBACK_SER_HDR_EN
        if (idx == 0) seq++;
`endif
        idx++;
        if (idx == WPL) begin
          void'(infl.pop_front());
          idx = 0;
          exp_lines++;
        end
      end
      if (rd_s) begin
        rden_cnt++;
        if (fifo.size() != 0) begin
          ln  = fifo.pop_front();
          pop = 1'b1;
          infl.push_back(ln);
        end
      end
    end
    #1;
    if (pop) rdata = ln;
    else rdata = {8{$urandom()}};
    empty = (fifo.size() == 0) || hold_empty;
  endtask

  task automatic push_line(input logic [LW-1:0] l);
    fifo.push_back(l);
    if (!hold_empty) empty = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {8{$urandom()}} ^ {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || infl.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n >= budget), 64'd0);
  endtask

  initial begin
    int            r0;
    int            n;
    int            pushed;
    bit            stalled;
    logic [LW-1:0] l1;

    vectors     = 0;
    miscompares = 0;
    want_valid  = -1;
    want_lines  = -1;
    hold_empty  = 1'b0;
    p_hold      = 1'b0;
    p_data      = '0;
    p_last      = 1'b0;
    idx         = 0;
    seq         = '0;
    exp_lines   = '0;
    rden_cnt    = 0;
    rst         = 1'b1;
    m_ready     = 1'b0;
    empty       = 1'b1;
    rdata       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rden", 64'(rden), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_lines", 64'(lines_sent), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    // Directed line: word i = i+1, first word two cycles after non-empty.
    for (int i = 0; i < N; i++) l1[i*OW +: OW] = OW'(i + 1);
    r0      = rden_cnt;
    m_ready = 1'b1;
    push_line(l1);
    step();
    step();
    want_valid = 1;
    drain(100);
    chk("t1_lines", 64'(lines_sent), 64'd1);
    chk("t1_rden_pulses", 64'(rden_cnt - r0), 64'd1);

    // Two queued lines: one LOAD bubble between them.
    r0 = rden_cnt;
    push_line(rand_line());
    push_line(rand_line());
    repeat (2 * WPL + 3) step();
    want_lines = 3;
    want_valid = 0;
    step();
    chk("t2_rden_pulses", 64'(rden_cnt - r0), 64'd2);

    // Toggling ready with a 20-cycle stall on the third word.
    r0      = rden_cnt;
    stalled = 1'b0;
    push_line(rand_line());
    n = 0;
    while ((fifo.size() != 0 || infl.size() != 0) && n < 300) begin
      if (!stalled && infl.size() != 0 && idx == 2 && m_valid) begin
        stalled = 1'b1;
        m_ready = 1'b0;
        repeat (20) step();
      end
      m_ready = ~m_ready;
      step();
      n++;
    end
    chk("t3_timeout", 64'(n >= 300), 64'd0);
    chk("t3_stalled", 64'(stalled), 64'd1);
    chk("t3_rden_pulses", 64'(rden_cnt - r0), 64'd1);

    // Reset mid-line after four words.
    m_ready = 1'b1;
    push_line(rand_line());
    push_line(rand_line());
    n = 0;
    while (!(infl.size() != 0 && idx == 4) && n < 50) begin
      step();
      n++;
    end
    chk("t4_timeout", 64'(n >= 50), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    want_valid = 0;
    want_lines = 0;
    step();
    drain(100);
    chk("t4_lines", 64'(lines_sent), 64'd1);

    // Empty held for 100 cycles even with a line waiting.
    r0         = rden_cnt;
    hold_empty = 1'b1;
    push_line(rand_line());
    empty = 1'b1;
    repeat (100) begin
      m_ready    = 1'($urandom_range(0, 1));
      want_valid = 0;
      step();
    end
    chk("t5_rden_pulses", 64'(rden_cnt - r0), 64'd0);
    hold_empty = 1'b0;
    empty      = 1'b0;
    drain(200);

`ifdef RDBACK_SER_HDR_EN
    // Fresh sequence numbers after reset: CAFE0000..CAFE0002.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_line(rand_line());
    drain(200);
    chk("hdr_lines", 64'(lines_sent), 64'd3);
`endif

    // Random pushes and random back-pressure.
    pushed = 0;
    n      = 0;
    while ((pushed < 8 || fifo.size() != 0 || infl.size() != 0)
           && n < 3000) begin
      if (pushed < 8 && $urandom_range(0, 5) == 0) begin
        push_line(rand_line());
        pushed++;
      end
      m_ready = ($urandom_range(0, 9) < 7);
      step();
      n++;
    end
    chk("t6_timeout", 64'(n >= 3000), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
